sram_req_ctrl: RTL

- Request-side controller that sits directly upstream of the single-port 2048x32 SRAM macro (we/addr/din in, registered dout out, no reset).
- Converts a valid/ready request stream into the macro's per-cycle access protocol.
- Captures read data one cycle after the access and returns it through a credit-protected response FIFO with valid/ready backpressure.
- Writes are posted and produce no response.

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_rsp_fifo.sv | 50 +++++
 rtl/sram_req_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and request type for the SRAM request controller and its response FIFO.
package sram_ctrl_pkg;

  localparam int SRAM_DW       = 32;
  localparam int SRAM_AW       = 11;
  localparam int RSP_DEPTH_DEF = 4;

  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] din;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO for read responses; output reads as zero while empty.
module sram_rsp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for a single-port SRAM macro: drives the macro directly from the
// request port and returns read data through a credit-limited response FIFO.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DW,
  parameter int ADDR_WIDTH = SRAM_AW,
  parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dout,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  idle
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  sram_req_t     req;
  logic          acc;
  logic          rd_pending;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;

  assign req = '{we: req_we, addr: req_addr, din: req_din};

  // A credit is held from acceptance until the response pops, so the FIFO can never overflow.
  assign req_ready = rst_n && ((count + CW'(rd_pending)) < CW'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;

  // Idle cycles still present the address; the resulting read data is simply never pushed.
  assign sram_we   = acc && req.we;
  assign sram_addr = req.addr;
  assign sram_din  = req.din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pending <= 1'b0;
    else        rd_pending <= acc && !req.we;
  end

  assign push = rd_pending;
  assign pop  = rsp_valid && rsp_ready;

  sram_rsp_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sram_dout),
    .pop   (pop),
    .dout  (rsp_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rsp_valid = !empty;
  assign idle      = !rd_pending && empty;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
